level_pump_controller: RTL

//  Sequences the fill pump from the registered GOET/LOET flags of the level threshold comparator.
//  - Debounces both flags.
//  - Enforces a minimum pump run time.
//  - Runs a fill-timeout watchdog.
//  - Latches a fault on timeout or on an impossible sensor state.

---
 rtl/level_pump_controller.sv | 101 ++++++++++
 1 files changed

// File: rtl/level_pump_controller.sv
// rtl/level_pump_controller.sv - fill pump sequencer with flag debounce, minimum run time and fill watchdog
// Filtered alarms feed the FSM; every output is a flop so the pump drive is glitch-free.
module level_pump_controller #(
  parameter int unsigned      CNT_W           = 32,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter logic [CNT_W-1:0] MIN_RUN_CYCLES  = 32'd500_000_000,
  parameter logic [CNT_W-1:0] FILL_TIMEOUT    = 32'd3_000_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       enable,
  input  logic       goet,
  input  logic       loet,
  input  logic       fault_clear,
  output logic       pump_on,
  output logic       alarm_high,
  output logic       alarm_low,
  output logic       fault,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FILL  = 2'b01;
  localparam logic [1:0] S_HOLD  = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  logic [1:0]       w_raw;
  logic [1:0]       r_filt;
  logic [CNT_W-1:0] r_db_cnt [2];
  logic [CNT_W-1:0] r_run_cnt;
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_pump_on;
  logic             r_fault;

  assign w_raw = {goet, loet};

  // Index 1 filters GOET, index 0 filters LOET.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_filt <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_raw[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DEBOUNCE_CYCLES - 1'b1) begin
          r_filt[i]   <= w_raw[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_filt[1] && r_filt[0]) begin
      w_next = S_FAULT;
    end else if (r_state != S_FAULT && !enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_filt[0]) w_next = S_FILL;
        // Reaching the level takes precedence over a coincident timeout.
        S_FILL: begin
          if (r_filt[1] && r_run_cnt >= MIN_RUN_CYCLES) w_next = S_HOLD;
          else if (r_run_cnt == FILL_TIMEOUT - 1'b1)     w_next = S_FAULT;
        end
        S_HOLD:  if (r_filt[0]) w_next = S_FILL;
        default: if (fault_clear) w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_run_cnt <= '0;
      r_pump_on <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pump_on <= (w_next == S_FILL);
      r_fault   <= (w_next == S_FAULT);
      if (r_state != S_FILL && w_next == S_FILL) begin
        r_run_cnt <= '0;
      end else if (r_state == S_FILL && r_run_cnt != FILL_TIMEOUT) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  assign pump_on    = r_pump_on;
  assign fault      = r_fault;
  assign alarm_high = r_filt[1];
  assign alarm_low  = r_filt[0];
  assign state      = r_state;

endmodule
